// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman symbol packer.
package huff_pkg;

  localparam int SYM_W  = 4;
  localparam int BYTE_W = 8;

  localparam logic [3:0] LEN1       = 4'd1;
  localparam logic [3:0] LEN4       = 4'd4;
  localparam logic [3:0] LEN5       = 4'd5;
  localparam logic [3:0] LEN6       = 4'd6;
  localparam logic [3:0] LEN_IDLE0  = 4'd0;
  localparam logic [3:0] LEN_IDLE10 = 4'd10;

  typedef enum logic {EMPTY, HALF} pack_state_e;

endpackage

// File: rtl/huff_byte_fifo.sv
// First-word-fall-through byte FIFO; push when full without a simultaneous pop is ignored.
module huff_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/huffman_symbol_packer.sv
// Packs decoded 4-bit symbols MSB-nibble-first into bytes, buffers them in a FIFO
// and streams them out on valid/ready while keeping saturating symbol/bit counts.
module huffman_symbol_packer
  import huff_pkg::*;
#(
  parameter int               FIFO_DEPTH = 8,
  parameter logic [SYM_W-1:0] PAD_NIBBLE = 4'h0,
  parameter int               CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SYM_W-1:0]  dec_data,
  input  logic [3:0]        dec_len,
  input  logic              dec_ready,
  input  logic              flush,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              len_err,
  output logic [CNT_W-1:0]  sym_count,
  output logic [CNT_W-1:0]  bit_count,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  pack_state_e       state_q, state_d;
  logic [SYM_W-1:0]  hold_q, hold_d;
  logic              overflow_q, len_err_q;
  logic [CNT_W-1:0]  sym_q, bit_q, sym_d, bit_d;
  logic [CNT_W:0]    sym_sum, bit_sum;
  logic              sym_stb, len_legal, len_idle;
  logic              push;
  logic [BYTE_W-1:0] push_byte;
  logic              pop, fifo_empty, fifo_full;
  logic [AW:0]       fifo_cnt;

  assign len_legal = (dec_len == LEN1) || (dec_len == LEN4) ||
                     (dec_len == LEN5) || (dec_len == LEN6);
  assign len_idle  = (dec_len == LEN_IDLE0) || (dec_len == LEN_IDLE10);
  assign sym_stb   = dec_ready && len_legal;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_byte = '0;
    case (state_q)
      EMPTY: begin
        if (sym_stb && flush) begin
          push      = 1'b1;
          push_byte = {dec_data, PAD_NIBBLE};
        end else if (sym_stb) begin
          hold_d  = dec_data;
          state_d = HALF;
        end
      end
      HALF: begin
        // A completing symbol takes priority; a concurrent flush has nothing left to pad.
        if (sym_stb) begin
          push      = 1'b1;
          push_byte = {hold_q, dec_data};
          state_d   = EMPTY;
        end else if (flush) begin
          push      = 1'b1;
          push_byte = {hold_q, PAD_NIBBLE};
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign sym_sum = {1'b0, sym_q} + 1'b1;
  assign bit_sum = {1'b0, bit_q} + {{(CNT_W-3){1'b0}}, dec_len};
  assign sym_d   = sym_sum[CNT_W] ? '1 : sym_sum[CNT_W-1:0];
  assign bit_d   = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      hold_q     <= '0;
      overflow_q <= 1'b0;
      len_err_q  <= 1'b0;
      sym_q      <= '0;
      bit_q      <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (push && fifo_full && !pop)                overflow_q <= 1'b1;
      if (dec_ready && !len_legal && !len_idle)     len_err_q  <= 1'b1;
      if (sym_stb) begin
        sym_q <= sym_d;
        bit_q <= bit_d;
      end
    end
  end

  huff_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_byte),
    .pop_i      (pop),
    .head_o     (out_data),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (fifo_cnt)
  );

  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q == HALF) || !fifo_empty;
  assign overflow  = overflow_q;
  assign len_err   = len_err_q;
  assign sym_count = sym_q;
  assign bit_count = bit_q;

endmodule

// File: tb/tb_huffman_symbol_packer.sv
// Randomized and directed bench for huffman_symbol_packer against a queue-based reference model.
module tb_huffman_symbol_packer;

  localparam int DEPTH  = 8;
  localparam int MAXCNT = 65535;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] dec_data = '0;
  logic [3:0] dec_len = '0;
  logic       dec_ready = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, overflow, len_err, busy;
  logic [15:0] sym_count, bit_count;

  huffman_symbol_packer #(.FIFO_DEPTH(DEPTH), .PAD_NIBBLE(4'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dec_data(dec_data), .dec_len(dec_len), .dec_ready(dec_ready),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .len_err(len_err), .sym_count(sym_count), .bit_count(bit_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_half;
  logic [3:0] m_hold;
  bit         m_ovf, m_lerr, m_zero;
  int         m_sym, m_bit;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] l);
    return l inside {4'd1, 4'd4, 4'd5, 4'd6};
  endfunction

  task automatic model_step(input bit rdy, input logic [3:0] len, input logic [3:0] dat,
                            input bit fl, input bit ordy);
    bit         have = 0;
    logic [7:0] b = '0;
    if (!rst) begin
      mq.delete();
      m_half = 0; m_hold = '0; m_ovf = 0; m_lerr = 0; m_zero = 1; m_sym = 0; m_bit = 0;
      return;
    end
    if (rdy && !is_legal(len) && !(len inside {4'd0, 4'd10})) m_lerr = 1;
    if (rdy && is_legal(len)) begin
      m_sym = (m_sym + 1 > MAXCNT) ? MAXCNT : m_sym + 1;
      m_bit = (m_bit + int'(len) > MAXCNT) ? MAXCNT : m_bit + int'(len);
      if (m_half)  begin b = {m_hold, dat}; have = 1; m_half = 0; end
      else if (fl) begin b = {dat, 4'h0};   have = 1; end
      else         begin m_hold = dat; m_half = 1; end
    end else if (fl && m_half) begin
      b = {m_hold, 4'h0}; have = 1; m_half = 0;
    end
    if (ordy && mq.size() > 0) void'(mq.pop_front());
    if (have) begin
      m_zero = 0;
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input bit rdy, input logic [3:0] len, input logic [3:0] dat,
                      input bit fl, input bit ordy);
    @(negedge clk);
    dec_ready = rdy; dec_len = len; dec_data = dat; flush = fl; out_ready = ordy;
    model_step(rdy, len, dat, fl, ordy);
    @(posedge clk);
    #1;
    check_eq("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0)  check_eq("out_data", out_data, mq[0]);
    else if (m_zero)     check_eq("out_data_rst", out_data, 0);
    check_eq("overflow", overflow, m_ovf);
    check_eq("len_err", len_err, m_lerr);
    check_eq("sym_count", sym_count, m_sym);
    check_eq("bit_count", bit_count, m_bit);
    check_eq("busy", busy, m_half || mq.size() != 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  task automatic legal_sym(input bit ordy);
    logic [3:0] lens [4] = '{4'd1, 4'd4, 4'd5, 4'd6};
    step(1, lens[$urandom_range(0, 3)], 4'($urandom), 0, ordy);
  endtask

  initial begin
    // Reset state and the basic pair A,5
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    step(1, 4, 4'hA, 0, 1);
    check_eq("a5_not_yet", out_valid, 0);
    step(1, 6, 4'h5, 0, 1);
    check_eq("a5_beat", out_data, 8'hA5);
    check_eq("a5_syms", sym_count, 2);
    check_eq("a5_bits", bit_count, 10);
    step(0, 0, 0, 0, 1);
    check_eq("a5_idle_busy", busy, 0);

    // Flush of a held nibble, and strobe+flush from EMPTY
    step(1, 1, 4'h3, 0, 1);
    step(0, 0, 0, 1, 1);
    check_eq("flush_30", out_data, 8'h30);
    step(1, 4, 4'h7, 1, 1);
    check_eq("flush_70", out_data, 8'h70);
    step(0, 0, 0, 0, 1);

    // Idle and illegal lengths
    do_reset();
    step(1, 10, 4'h9, 0, 1);
    step(1, 0, 4'h9, 0, 1);
    check_eq("idle_no_err", len_err, 0);
    check_eq("idle_no_sym", sym_count, 0);
    step(1, 3, 4'h9, 0, 1);
    check_eq("bad_len_err", len_err, 1);
    check_eq("bad_len_nosym", sym_count, 0);

    // Overflow: 18 symbols into a stalled 8-deep FIFO, then drain
    do_reset();
    for (int i = 0; i < 18; i++) legal_sym(0);
    check_eq("ovf_set", overflow, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    check_eq("ovf_drained", out_valid, 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) legal_sym(0);
    legal_sym(0);
    legal_sym(1);
    check_eq("full_pp_no_ovf", overflow, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
    check_eq("full_pp_one_left", out_valid, 1);
    step(0, 0, 0, 0, 1);
    check_eq("full_pp_empty", out_valid, 0);

    // Stall with 3 bytes and a half byte pending, then reset mid-operation
    do_reset();
    for (int i = 0; i < 7; i++) legal_sym(0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 4, 4'h1, 1, 1);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_sym", sym_count, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 1);
    check_eq("postrst_valid", out_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] len;
      len = ($urandom_range(0, 1) == 0) ? 4'($urandom) :
            ((($urandom_range(0, 3)) == 0) ? 4'd1 : 4'($urandom_range(4, 6)));
      rst = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 99) < 60, len, 4'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) < 60);
    end
    rst = 1'b1;

    // Bit counter saturation
    do_reset();
    for (int i = 0; i < 11000; i++) step(1, 6, 4'($urandom), 0, 1);
    check_eq("bit_sat", bit_count, 16'hFFFF);
    check_eq("sym_nosat", sym_count, 11000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
